// File: rtl/pipelined_reduce_unit.sv
// Pipelined FANIN-ary reduction tree (OR/AND/XOR/NOR) with valid/ready flow control.
// Optional REDUCE_STATS_EN adds a saturating RESULT_CNT handshake counter.
module pipelined_reduce_unit #(
  parameter int WIDTH = 32,
  parameter int FANIN = 4
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic [1:0]       IN_OP,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             OUT_RESULT,
  output logic [1:0]       OUT_OP
`ifdef REDUCE_STATS_EN
  ,
  output logic [15:0]      RESULT_CNT
`endif
);

  function automatic int stage_w(int k);
    int w;
    w = WIDTH;
    for (int i = 0; i <= k; i++) w = (w + FANIN - 1) / FANIN;
    return w;
  endfunction

  function automatic int num_levels();
    int w, n;
    w = WIDTH;
    n = 0;
    while (w > 1) begin
      w = (w + FANIN - 1) / FANIN;
      n++;
    end
    return n;
  endfunction

  function automatic int stage_off(int k);
    int o;
    o = 0;
    for (int i = 0; i < k; i++) o += stage_w(i);
    return o;
  endfunction

  localparam int LEVELS = num_levels();
  localparam int TOT    = stage_off(LEVELS);

  logic                   rst_ok_q;
  logic [LEVELS-1:0]      vld_q, rdy, vin, ld;
  logic [LEVELS-1:0][1:0] op_q, opin;
  // All stage partial vectors packed back to back; last stage is the MSB.
  logic [TOT-1:0]         part_q, part_d, ld_bit;

  for (genvar k = 0; k < LEVELS; k++) begin : g_st
    localparam int WI   = (k == 0) ? WIDTH : stage_w(k - 1);
    localparam int WO   = stage_w(k);
    localparam int OO   = stage_off(k);
    localparam int PADW = WO * FANIN - WI;

    logic [WI-1:0]       src;
    logic [WO*FANIN-1:0] padded;
    logic [WO-1:0]       red;
    logic [FANIN-1:0]    grp;

    if (k == 0) begin : g_in
      assign src     = IN_DATA;
      assign vin[k]  = IN_VALID & IN_READY;
      assign opin[k] = IN_OP;
    end else begin : g_mid
      assign src     = part_q[stage_off(k - 1) +: WI];
      assign vin[k]  = vld_q[k - 1];
      assign opin[k] = op_q[k - 1];
    end

    // Ragged top node is filled with the op's identity (1 only for AND).
    if (PADW > 0) begin : g_pad
      assign padded = {{PADW{opin[k] == 2'b01}}, src};
    end else begin : g_nopad
      assign padded = src;
    end

    always_comb begin
      red = '0;
      grp = '0;
      for (int j = 0; j < WO; j++) begin
        grp = padded[j*FANIN +: FANIN];
        case (opin[k])
          2'b01:   red[j] = &grp;
          2'b10:   red[j] = ^grp;
          default: red[j] = |grp;
        endcase
      end
    end

    // A stage can advance unless it and every stage after it are full and stalled.
    assign rdy[k]             = OUT_READY | ~(&vld_q[LEVELS-1:k]);
    assign ld[k]              = rdy[k] & vin[k] & ~FLUSH;
    assign part_d[OO +: WO]   = red ^ {WO{(k == LEVELS - 1) && (opin[k] == 2'b11)}};
    assign ld_bit[OO +: WO]   = {WO{ld[k]}};
  end

  assign IN_READY   = rdy[0] & ~FLUSH & RSTN & rst_ok_q;
  assign OUT_VALID  = vld_q[LEVELS-1];
  assign OUT_OP     = op_q[LEVELS-1];
  assign OUT_RESULT = part_q[TOT-1];

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rst_ok_q <= 1'b0;
      vld_q    <= '0;
      op_q     <= '0;
      part_q   <= '0;
    end else begin
      rst_ok_q <= 1'b1;
      vld_q    <= FLUSH ? '0 : ((vld_q & ~rdy) | (vin & rdy));
      for (int k = 0; k < LEVELS; k++)
        if (ld[k]) op_q[k] <= opin[k];
      for (int i = 0; i < TOT; i++)
        if (ld_bit[i]) part_q[i] <= part_d[i];
    end
  end

`ifdef REDUCE_STATS_EN
  logic [15:0] cnt_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)
      cnt_q <= '0;
    else if (OUT_VALID && OUT_READY && cnt_q != 16'hFFFF)
      cnt_q <= cnt_q + 16'd1;
  end

  assign RESULT_CNT = cnt_q;
`endif

endmodule
